vga_box_renderer: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/box_axis_mover.sv | 63 ++++++
 rtl/vga_box_renderer.sv | 82 ++++++++
 tb/tb_vga_box_renderer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Constants and types shared by the VGA timing generator and the pixel stages.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    localparam logic [5:0] BG_COLOUR = 6'b000001;

    // RRGGBB entries, index 0 in the least significant slot:
    // red, green, blue, yellow, cyan, magenta, white, orange.
    localparam logic [7:0][5:0] PALETTE = {
        6'b111000,
        6'b111111,
        6'b110011,
        6'b001111,
        6'b111100,
        6'b000011,
        6'b001100,
        6'b110000
    };

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

endpackage

// File: rtl/box_axis_mover.sv
// One axis of the bouncing box: position register, travel direction and
// bounce detection against 0 and LIMIT-BOX_SIZE.
module box_axis_mover #(
    parameter int LIMIT    = 640,
    parameter int BOX_SIZE = 32,
    parameter int SPEED    = 2,
    parameter int INIT     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    output logic [9:0] pos_o,
    output logic       bounce_o
);
    import vga_pkg::*;

    localparam logic [10:0] MAX_POS = 11'(LIMIT - BOX_SIZE);
    localparam logic [10:0] SPD     = 11'(SPEED);

    logic [9:0]  pos_q, pos_d;
    dir_t        dir_q, dir_d;
    logic [10:0] pos_ext;

    assign pos_ext = {1'b0, pos_q};
    assign pos_o   = pos_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= 10'(INIT);
            dir_q <= DIR_FWD;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    // A step that would reach or pass an edge clamps onto it and reverses.
    always_comb begin
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_o = 1'b0;
        if (step_i) begin
            if (dir_q == DIR_FWD) begin
                if (pos_ext + SPD >= MAX_POS) begin
                    pos_d    = MAX_POS[9:0];
                    dir_d    = DIR_REV;
                    bounce_o = 1'b1;
                end else begin
                    pos_d = pos_q + SPD[9:0];
                end
            end else begin
                if (pos_ext <= SPD) begin
                    pos_d    = '0;
                    dir_d    = DIR_FWD;
                    bounce_o = 1'b1;
                end else begin
                    pos_d = pos_q - SPD[9:0];
                end
            end
        end
    end

endmodule

// File: rtl/vga_box_renderer.sv
// Pixel stage after the VGA timing generator: draws a bouncing, colour-cycling
// square and registers RGB together with both syncs (one-cycle latency).
module vga_box_renderer #(
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int BOX_SIZE  = 32,
    parameter int SPEED     = 2,
    parameter int INIT_X    = 64,
    parameter int INIT_Y    = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pause,
    output logic [5:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out
);
    import vga_pkg::*;

    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    logic       tick, step;
    logic [9:0] box_x, box_y;
    logic       bounce_x, bounce_y;
    logic [2:0] colour_idx_q, colour_idx_d;
    logic       inside_x, inside_y;
    logic [5:0] rgb_q, rgb_d;
    logic       hsync_q, vsync_q;

    // First pixel of the first blanking line: once per frame, never visible.
    assign tick = (x == 10'd0) && (y == 10'(V_DISPLAY));
    assign step = tick && !pause;

    box_axis_mover #(
        .LIMIT(H_DISPLAY), .BOX_SIZE(BOX_SIZE), .SPEED(SPEED), .INIT(INIT_X)
    ) u_mover_x (
        .clk(clk), .rst(rst), .step_i(step), .pos_o(box_x), .bounce_o(bounce_x)
    );

    box_axis_mover #(
        .LIMIT(V_DISPLAY), .BOX_SIZE(BOX_SIZE), .SPEED(SPEED), .INIT(INIT_Y)
    ) u_mover_y (
        .clk(clk), .rst(rst), .step_i(step), .pos_o(box_y), .bounce_o(bounce_y)
    );

    // A corner hit bounces both axes but still advances the colour only once.
    assign colour_idx_d = colour_idx_q + 3'(step && (bounce_x || bounce_y));

    assign inside_x = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < {1'b0, box_x} + BOX_W);
    assign inside_y = ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < {1'b0, box_y} + BOX_W);

    always_comb begin
        rgb_d = '0;
        if (active) begin
            rgb_d = (inside_x && inside_y) ? PALETTE[colour_idx_q] : BG_COLOUR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour_idx_q <= '0;
            rgb_q        <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
        end else begin
            colour_idx_q <= colour_idx_d;
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_in;
            vsync_q      <= vsync_in;
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Bench for vga_box_renderer: three instances (default, right-edge, corner start)
// driven in lockstep and compared every cycle against a frame-level model.
module tb_vga_box_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       active, hs_in, vs_in, pause;
    logic [5:0] rgb_w [3];
    logic       hs_w  [3];
    logic       vs_w  [3];

    int checks   = 0;
    int failures = 0;

    // Model of the three boxes (frame-level state).
    int ix [3] = '{64, 606, 606};
    int iy [3] = '{48, 48, 446};
    int mx [3], my [3], mc [3];
    bit right [3], down [3];
    logic [5:0] PAL [8] = '{6'b110000, 6'b001100, 6'b000011, 6'b111100,
                            6'b001111, 6'b110011, 6'b111111, 6'b111000};
    localparam logic [5:0] BG = 6'b000001;

    always #5 clk = ~clk;

    vga_box_renderer #(.INIT_X(64), .INIT_Y(48)) dut0 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hs_in),
        .vsync_in(vs_in), .pause(pause), .rgb(rgb_w[0]), .hsync_out(hs_w[0]), .vsync_out(vs_w[0]));
    vga_box_renderer #(.INIT_X(606), .INIT_Y(48)) dut1 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hs_in),
        .vsync_in(vs_in), .pause(pause), .rgb(rgb_w[1]), .hsync_out(hs_w[1]), .vsync_out(vs_w[1]));
    vga_box_renderer #(.INIT_X(606), .INIT_Y(446)) dut2 (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hs_in),
        .vsync_in(vs_in), .pause(pause), .rgb(rgb_w[2]), .hsync_out(hs_w[2]), .vsync_out(vs_w[2]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mx[i] = ix[i]; my[i] = iy[i]; mc[i] = 0; right[i] = 1; down[i] = 1;
        end
    endtask

    // One frame of motion: move SPEED=2, stop on the edge and turn round.
    task automatic model_tick();
        bit hit;
        if (pause) return;
        for (int i = 0; i < 3; i++) begin
            hit = 0;
            if (right[i]) begin
                if (mx[i] + 2 >= 640 - 32) begin mx[i] = 608; right[i] = 0; hit = 1; end
                else mx[i] = mx[i] + 2;
            end else begin
                if (mx[i] <= 2) begin mx[i] = 0; right[i] = 1; hit = 1; end
                else mx[i] = mx[i] - 2;
            end
            if (down[i]) begin
                if (my[i] + 2 >= 480 - 32) begin my[i] = 448; down[i] = 0; hit = 1; end
                else my[i] = my[i] + 2;
            end else begin
                if (my[i] <= 2) begin my[i] = 0; down[i] = 1; hit = 1; end
                else my[i] = my[i] - 2;
            end
            if (hit) mc[i] = (mc[i] + 1) % 8;
        end
    endtask

    function automatic logic [5:0] exp_rgb(int i, int xx, int yy, bit act);
        if (!act) return 6'd0;
        if (xx >= mx[i] && xx < mx[i] + 32 && yy >= my[i] && yy < my[i] + 32) return PAL[mc[i]];
        return BG;
    endfunction

    task automatic cyc(input int xx, input int yy, input bit act, input bit hs, input bit vs);
        x = 10'(xx); y = 10'(yy); active = act; hs_in = hs; vs_in = vs;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rgb%0d@(%0d,%0d,a%0d)", i, xx, yy, act), 8'(rgb_w[i]), 8'(exp_rgb(i, xx, yy, act)));
            chk($sformatf("hsync%0d", i), 8'(hs_w[i]), 8'(hs));
            chk($sformatf("vsync%0d", i), 8'(vs_w[i]), 8'(vs));
        end
        if (xx == 0 && yy == 480) model_tick();
    endtask

    task automatic tick();
        cyc(0, 480, 0, 1, 1);
    endtask

    task automatic probe(input int xx, input int yy);
        if (xx < 0 || yy < 0 || xx > 1023 || yy > 1023 || (xx == 0 && yy == 480)) return;
        cyc(xx, yy, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic probe_all();
        for (int i = 0; i < 3; i++) begin
            probe(mx[i], my[i]);
            probe(mx[i] - 1, my[i]);
            probe(mx[i] + 31, my[i] + 31);
            probe(mx[i] + 32, my[i]);
            probe(mx[i], my[i] + 32);
            probe(mx[i], my[i] - 1);
        end
    endtask

    initial begin
        int rx, ry;
        rst = 1; x = 0; y = 0; active = 0; hs_in = 0; vs_in = 0; pause = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_rgb", 8'(rgb_w[i]), 8'd0);
            chk("reset_hsync", 8'(hs_w[i]), 8'd1);
            chk("reset_vsync", 8'(vs_w[i]), 8'd1);
        end
        model_reset();
        rst = 0;
        cyc(10, 10, 0, 0, 1);

        // Inside test and latency right after reset.
        cyc(64, 48, 1, 1, 1);
        cyc(63, 48, 1, 1, 1);
        cyc(96, 48, 1, 1, 1);
        cyc(64, 48, 0, 1, 1);

        // First frame: move, edge bounce and corner bounce.
        tick();
        probe_all();
        cyc(66, 50, 1, 1, 1);
        cyc(65, 50, 1, 1, 1);
        tick();
        probe_all();

        // Frozen across three ticks.
        pause = 1;
        repeat (3) tick();
        probe_all();
        pause = 0;

        // Randomised frames and pixels.
        for (int n = 0; n < 40; n++) begin
            pause = ($urandom_range(0, 3) == 0);
            tick();
            pause = 0;
            probe_all();
            for (int k = 0; k < 8; k++) begin
                rx = $urandom_range(0, 799);
                ry = $urandom_range(0, 524);
                if (rx == 0 && ry == 480) rx = 1;
                cyc(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Asynchronous reset in the middle of a visible line.
        cyc(300, 48, 1, 0, 0);
        #2 rst = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midreset_rgb", 8'(rgb_w[i]), 8'd0);
            chk("midreset_hsync", 8'(hs_w[i]), 8'd1);
            chk("midreset_vsync", 8'(vs_w[i]), 8'd1);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        probe_all();
        tick();
        probe_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
